// File: rtl/md_route_pkg.sv
// Shared routing definitions for the motion-update return path: default
// geometry, lane-index constants and the select range helper that the
// selection mux and the dispatch demux both use.
package md_route_pkg;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int SEL_WIDTH_DEF  = 3;
    localparam int NUM_OUT_DEF    = 8;

    localparam int LANE_FIRST = 0;
    localparam int LANE_LAST  = NUM_OUT_DEF - 1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // True when sel names an existing lane; num_out defaults to the
    // standard lane count so most callers pass only the select.
    function automatic logic lane_in_range(input int unsigned sel,
                                           input int unsigned num_out = NUM_OUT_DEF);
        return (sel < num_out);
    endfunction

endpackage

// File: rtl/demux_lane_slot.sv
// Single-entry holding register for one output lane. A load while full is
// only ever issued together with a drain, so the new word replaces the
// departing one and the slot stays full.
module demux_lane_slot
    import md_route_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  drain,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data
);

    slot_state_t state;

    // EMPTY/FULL state and held word; data keeps its last value after a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_EMPTY;
            data  <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: begin
                    if (load) begin
                        state <= SLOT_FULL;
                        data  <= load_data;
                    end
                end
                SLOT_FULL: begin
                    if (load) begin
                        data <= load_data;
                    end else if (drain) begin
                        state <= SLOT_EMPTY;
                    end
                end
                default: state <= SLOT_EMPTY;
            endcase
        end
    end

    assign full = (state == SLOT_FULL);

endmodule

// File: rtl/data_demux_dispatch.sv
// Registered 1-to-NUM_OUT demultiplexer. Each accepted word is parked in the
// holding slot of the lane named by in_sel; lanes drain independently so a
// stalled consumer only blocks words addressed to itself. Selects beyond the
// last lane are swallowed and tallied in a saturating drop counter.
module data_demux_dispatch
    import md_route_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_OUT    = NUM_OUT_DEF,
    parameter int SEL_WIDTH  = SEL_WIDTH_DEF,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [SEL_WIDTH-1:0]          in_sel,
    output logic [NUM_OUT-1:0]            out_valid,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
    input  logic [NUM_OUT-1:0]            out_ready,
    output logic [CNT_WIDTH-1:0]          drop_cnt,
    output logic                          busy
);

    localparam int SEL_SPAN = 2 ** SEL_WIDTH;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic                sel_ok;
    logic                accept;
    logic [SEL_SPAN-1:0] valid_pad;
    logic [SEL_SPAN-1:0] ready_pad;
    logic [NUM_OUT-1:0]  lane_load;

    assign sel_ok = lane_in_range(32'(in_sel), NUM_OUT);

    // Widen lane status to the full select span so any select indexes safely.
    always_comb begin
        valid_pad                = '0;
        ready_pad                = '0;
        valid_pad[NUM_OUT-1:0]   = out_valid;
        ready_pad[NUM_OUT-1:0]   = out_ready;
    end

    // Ready when the target slot is empty or draining; out-of-range is a sink.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (sel_ok) begin
                in_ready = ~valid_pad[in_sel] | ready_pad[in_sel];
            end else begin
                in_ready = 1'b1;
            end
        end
    end

    assign accept = in_valid & in_ready;

    // One-hot load strobe for the addressed lane only.
    always_comb begin
        lane_load = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            lane_load[i] = accept & sel_ok & (in_sel == SEL_WIDTH'(i));
        end
    end

    // Count words discarded for a select with no lane behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (accept && !sel_ok) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_lane
        demux_lane_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (lane_load[g]),
            .load_data (in_data),
            .drain     (out_ready[g]),
            .full      (out_valid[g]),
            .data      (out_data[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign busy = |out_valid;

endmodule

// File: tb/tb_data_demux_dispatch.sv
// Bench for data_demux_dispatch: an 8-lane instance (a_*) and a 6-lane
// instance with a 3-bit drop counter (b_*), driven in lockstep. Accepted
// words are pushed to per-lane queues and popped when that lane drains.
module tb_data_demux_dispatch;

    logic clk = 1'b0;
    logic rst;

    logic        a_in_valid, a_in_ready;
    logic [3:0]  a_in_data;
    logic [2:0]  a_in_sel;
    logic [7:0]  a_out_valid, a_out_ready;
    logic [31:0] a_out_data;
    logic [7:0]  a_drop_cnt;
    logic        a_busy;

    logic        b_in_valid, b_in_ready;
    logic [3:0]  b_in_data;
    logic [2:0]  b_in_sel;
    logic [5:0]  b_out_valid, b_out_ready;
    logic [23:0] b_out_data;
    logic [2:0]  b_drop_cnt;
    logic        b_busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] qa[8][$];
    logic [3:0] qb[6][$];
    int exp_drop_a = 0;
    int exp_drop_b = 0;

    always #5 clk = ~clk;

    data_demux_dispatch u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_sel    (a_in_sel),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_ready (a_out_ready),
        .drop_cnt  (a_drop_cnt),
        .busy      (a_busy)
    );

    data_demux_dispatch #(
        .NUM_OUT   (6),
        .CNT_WIDTH (3)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_ready (b_out_ready),
        .drop_cnt  (b_drop_cnt),
        .busy      (b_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Score the handshakes about to happen at the next edge, then advance
    // to the following falling edge.
    task automatic tick();
        logic [3:0] e;
        #1;
        if (rst) begin
            for (int i = 0; i < 8; i++) qa[i].delete();
            for (int i = 0; i < 6; i++) qb[i].delete();
            exp_drop_a = 0;
            exp_drop_b = 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (a_out_valid[i] && a_out_ready[i]) begin
                    if (qa[i].size() == 0) begin
                        check_eq("a_unexpected_word", 32'(i), 32'hFF);
                    end else begin
                        e = qa[i].pop_front();
                        check_eq("a_lane_data", 32'(a_out_data[i*4 +: 4]), 32'(e));
                    end
                end
            end
            for (int i = 0; i < 6; i++) begin
                if (b_out_valid[i] && b_out_ready[i]) begin
                    if (qb[i].size() == 0) begin
                        check_eq("b_unexpected_word", 32'(i), 32'hFF);
                    end else begin
                        e = qb[i].pop_front();
                        check_eq("b_lane_data", 32'(b_out_data[i*4 +: 4]), 32'(e));
                    end
                end
            end
            if (a_in_valid && a_in_ready) qa[a_in_sel].push_back(a_in_data);
            if (b_in_valid && b_in_ready) begin
                if (b_in_sel < 6) qb[b_in_sel].push_back(b_in_data);
                else if (exp_drop_b < 7) exp_drop_b++;
            end
        end
        @(negedge clk);
        check_eq("a_drop_cnt", 32'(a_drop_cnt), 32'(exp_drop_a));
        check_eq("b_drop_cnt", 32'(b_drop_cnt), 32'(exp_drop_b));
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_in_data = 0; a_in_sel = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = 0; b_in_sel = 0; b_out_ready = 0;
        @(negedge clk);
        check_eq("a_in_ready_in_reset", 32'(a_in_ready), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        check_eq("a_out_valid_reset", 32'(a_out_valid), 32'h00);
        check_eq("a_busy_reset", 32'(a_busy), 32'h0);
        check_eq("b_out_valid_reset", 32'(b_out_valid), 32'h00);
        for (int s = 0; s < 8; s++) begin
            a_in_sel = 3'(s);
            #1;
            check_eq("a_in_ready_idle", 32'(a_in_ready), 32'h1);
            tick();
        end

        // Fill lanes 2 and 5, then reset with them held.
        a_out_ready = 8'h00;
        a_in_valid = 1; a_in_sel = 3'd2; a_in_data = 4'h3; tick();
        a_in_sel = 3'd5; a_in_data = 4'h6; tick();
        a_in_valid = 0;
        check_eq("a_full_2_5", 32'(a_out_valid), 32'h24);
        check_eq("a_busy_full", 32'(a_busy), 32'h1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("a_out_valid_after_rst", 32'(a_out_valid), 32'h00);
        check_eq("a_out_data_after_rst", a_out_data, 32'h0);
        check_eq("a_busy_after_rst", 32'(a_busy), 32'h0);

        // Route sweep with every lane ready.
        a_out_ready = 8'hFF;
        for (int s = 0; s < 8; s++) begin
            a_in_valid = 1; a_in_sel = 3'(s); a_in_data = 4'(s + 1);
            tick();
            check_eq("sweep_valid", 32'(a_out_valid), 32'(8'(1) << s));
            check_eq("sweep_data", 32'(a_out_data[s*4 +: 4]), 32'(s + 1));
        end
        a_in_valid = 0;
        tick();
        check_eq("sweep_idle", 32'(a_out_valid), 32'h00);

        // Backpressure on lane 3.
        a_out_ready = 8'hF7;
        a_in_valid = 1; a_in_sel = 3'd3; a_in_data = 4'hA; tick();
        check_eq("bp_lane3_full", 32'(a_out_valid[3]), 32'h1);
        a_in_data = 4'hB;
        #1;
        check_eq("bp_lane3_blocked", 32'(a_in_ready), 32'h0);
        tick();
        a_in_sel = 3'd4; a_in_data = 4'h7;
        #1;
        check_eq("bp_lane4_ready", 32'(a_in_ready), 32'h1);
        tick();
        check_eq("bp_lane3_4_full", 32'(a_out_valid), 32'h18);
        a_out_ready = 8'hFF; a_in_sel = 3'd3; a_in_data = 4'hB;
        #1;
        check_eq("bp_release_ready", 32'(a_in_ready), 32'h1);
        tick();
        check_eq("bp_lane3_still_full", 32'(a_out_valid[3]), 32'h1);
        check_eq("bp_lane3_new_word", 32'(a_out_data[12 +: 4]), 32'hB);
        a_in_valid = 0;
        tick();
        tick();

        // Out-of-range selects on the 6-lane instance.
        b_out_ready = 6'h00;
        for (int k = 0; k < 6; k++) begin
            b_in_valid = 1; b_in_sel = (k < 3) ? 3'd6 : 3'd7; b_in_data = 4'(k);
            #1;
            check_eq("oor_in_ready", 32'(b_in_ready), 32'h1);
            tick();
        end
        check_eq("oor_no_lane", 32'(b_out_valid), 32'h00);
        check_eq("oor_drop6", 32'(b_drop_cnt), 32'h6);
        for (int k = 0; k < 10; k++) begin
            b_in_sel = 3'd7; tick();
        end
        b_in_valid = 0;
        check_eq("sat_drop7", 32'(b_drop_cnt), 32'h7);

        // Random soak on both instances.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_in_sel    = 3'($urandom_range(0, 7));
            a_in_data   = 4'($urandom);
            a_out_ready = 8'($urandom);
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_sel    = 3'($urandom_range(0, 7));
            b_in_data   = 4'($urandom);
            b_out_ready = 6'($urandom);
            tick();
        end
        a_in_valid = 0; b_in_valid = 0;
        a_out_ready = 8'hFF; b_out_ready = 6'h3F;
        tick(); tick(); tick();
        for (int i = 0; i < 8; i++) check_eq("a_queue_drained", 32'(qa[i].size()), 32'h0);
        for (int i = 0; i < 6; i++) check_eq("b_queue_drained", 32'(qb[i].size()), 32'h0);
        check_eq("a_idle_end", 32'(a_out_valid), 32'h00);
        check_eq("b_idle_end", 32'(b_out_valid), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
